vga_cell_capture: RTL
=====================

# vga_cell_capture

Receive-side counterpart of the VGA cell-grid video generator. It watches an incoming VGA stream and recovers pixel coordinates from the sync pulses. It samples the centre pixel of every 32×32 cell, quantises the colour to 6 bits, and writes one byte per cell into the 9-bit-addressed video memory. This lets a generator output be looped back and checked against the memory it was drawn from.

## Interface
Parameters:
- H_TOTAL, 801: clocks from one HS falling edge to the next
- H_SYNC_TO_ACTIVE, 144: clocks from HS falling edge to active pixel x=0
- H_ACTIVE, 640: active pixels per line
- V_TOTAL, 526: lines from one VS falling edge to the next
- VS_TO_ACTIVE, 35: HS falling edges after VS falling edge before active line y=0
- V_ACTIVE, 480: active lines
- BASE_ADDR, 212: memory address of cell (row 0, col 0)

Ports:
- clk  in  1  pixel clock; the stream is synchronous to it
- reset_n  in  1  synchronous, active-low reset
- VGA_HS_I  in  1  horizontal sync, active-low
- VGA_VS_I  in  1  vertical sync, active-low
- VGA_R_I, VGA_G_I, VGA_B_I  in  8 each  pixel colour
- wr_en  out  1  memory write strobe, one cycle per cell
- wr_addr  out  9  BASE_ADDR + col + 20·row
- wr_data  out  8  {2'b00, R[7:6], G[7:6], B[7:6]}
- locked  out  1  high while in CAPTURE
- frame_done  out  1  one-cycle pulse after a complete captured frame
- frame_sig  out  8  per-frame signature (see Configuration)

## Operation
- Inputs are registered once, then edge-detected. HS fall and VS fall are single-cycle events.
- Counters:
  - hcnt (10 b): cleared to 0 on the cycle of an HS fall, otherwise +1, saturating at 1023.
  - vcnt (10 b): cleared on VS fall; +1 on each HS fall.
- Active coordinates:
  - ax = hcnt − H_SYNC_TO_ACTIVE, valid when 0 ≤ ax < H_ACTIVE.
  - ay = vcnt − VS_TO_ACTIVE, valid when 0 ≤ ay < V_ACTIVE.
  - col = ax[9:5] (0..19), row = ay[8:5] (0..14).
- Sample point: ax[4:0]==16 and ay[4:0]==16, both valid. Otherwise no sample.
- FSM:
  - SEARCH → WAIT_VS after two consecutive HS periods each exactly H_TOTAL.
  - WAIT_VS → CAPTURE on VS fall.
  - CAPTURE → SEARCH if any HS period ≠ H_TOTAL.
  - CAPTURE → SEARCH if a VS fall arrives with vcnt+1 ≠ V_TOTAL.
  - A lock drop aborts the frame: no frame_done, and remaining cells are not written.
- Writes occur only in CAPTURE: 300 writes per frame, addresses 212..511, in raster order (row-major).
- frame_done: on a VS fall in CAPTURE when all 300 cells were written this frame and the frame length is correct. The FSM stays in CAPTURE.
- Simultaneous HS fall and VS fall: vcnt clears to 0; the HS event does not increment it.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, locked=0, frame_done=0, frame_sig=0, FSM=SEARCH, hcnt=vcnt=0.
- Write latency: the sample-point pixel at the module inputs at cycle t produces wr_en/addr/data at cycle t+2. There is one input register stage and one output register stage.
- wr_en is high for exactly one cycle per cell. No back-pressure; the memory accepts every write.
- locked rises the cycle after the VS fall that enters CAPTURE. It falls the cycle after the offending HS or VS edge.
- frame_done asserts at cycle t+2 relative to the qualifying VS fall at the inputs.
- reset_n low mid-frame takes effect at the next clk edge. The block returns to SEARCH and must relock, needing ≥2 full lines plus a VS.

## Configuration
- VGA_CAP_SIG_EN defined:
  - An 8-bit accumulator XORs each wr_data, rotated left by 1 before each XOR.
  - It clears on VS fall.
  - frame_sig loads the accumulator value with frame_done.
- VGA_CAP_SIG_EN undefined: the accumulator is not built and frame_sig is constant 0.

## Test plan
- Nominal: generator-timed stream, every pixel R=G=B=8'hFF → after lock, 300 writes per frame, wr_addr 212..511 ascending, wr_data=8'h3F, one frame_done per frame.
- Pattern: pixel colour = {col[1:0],6'b0} on R, other channels 0 → wr_data=8'h10·(col mod 4) at each address. Confirm the cell at col 19, row 14 writes addr 511 with 8'h30.
- Lock loss: a single line of 800 clocks mid-frame → locked falls, writes stop, no frame_done. Relock on the following VS with two good lines.
- Bad frame length: a frame of 525 lines → locked drops at that VS fall and frame_done is not pulsed.
- Reset mid-frame: reset_n low one cycle at line 200 → all outputs 0 next cycle, FSM in SEARCH, first write only after the next full-frame relock.
- With VGA_CAP_SIG_EN: all cells 8'h3F → frame_sig equals the precomputed rotate-XOR of 300 × 8'h3F. Without the macro, frame_sig stays 0.

Source files
------------

// File: rtl/vga_cell_capture_if.sv
// Video-in and cell-memory write signals of vga_cell_capture, grouped for the capture block (slave)
// and whatever drives the stream and observes the writes (master).
interface vga_cell_capture_if;
  logic       VGA_HS_I;
  logic       VGA_VS_I;
  logic [7:0] VGA_R_I;
  logic [7:0] VGA_G_I;
  logic [7:0] VGA_B_I;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output VGA_HS_I, VGA_VS_I, VGA_R_I, VGA_G_I, VGA_B_I,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  VGA_HS_I, VGA_VS_I, VGA_R_I, VGA_G_I, VGA_B_I,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vga_cell_capture.sv
// Locks onto a VGA stream, samples the centre pixel of each 32x32 cell and writes a 6-bit colour byte per cell.
// Write latency 2 clocks from the input pixel; define VGA_CAP_SIG_EN to build the per-frame rotate-XOR signature.
module vga_cell_capture #(
  parameter int H_TOTAL          = 801,
  parameter int H_SYNC_TO_ACTIVE = 144,
  parameter int H_ACTIVE         = 640,
  parameter int V_TOTAL          = 526,
  parameter int VS_TO_ACTIVE     = 35,
  parameter int V_ACTIVE         = 480,
  parameter int BASE_ADDR        = 212
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_cell_capture_if.slave bus,
  output logic              locked,
  output logic              frame_done,
  output logic [7:0]        frame_sig
);
  localparam int CELLS = (H_ACTIVE / 32) * (V_ACTIVE / 32);

  typedef enum logic [1:0] {SEARCH, WAIT_VS, CAPTURE} state_t;
  state_t state, state_nxt;

  logic       hs_q, hs_d, vs_q, vs_d;
  logic [1:0] r_q, g_q, b_q;
  logic       hs_fall, vs_fall;

  // Only the two colour MSBs survive quantisation, so only they are registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hs_q <= 1'b0;
      hs_d <= 1'b0;
      vs_q <= 1'b0;
      vs_d <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= bus.VGA_HS_I;
      hs_d <= hs_q;
      vs_q <= bus.VGA_VS_I;
      vs_d <= vs_q;
      r_q  <= bus.VGA_R_I[7:6];
      g_q  <= bus.VGA_G_I[7:6];
      b_q  <= bus.VGA_B_I[7:6];
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign vs_fall = vs_d & ~vs_q;

  logic [9:0] hcnt, vcnt, hcnt_now, vcnt_now;
  logic       hs_period_ok, vs_len_ok;

  // hcnt_now/vcnt_now are the coordinates of the pixel currently in the input register.
  always_comb begin
    hcnt_now = (hcnt == 10'h3FF) ? hcnt : hcnt + 10'd1;
    if (hs_fall) hcnt_now = '0;
    vcnt_now = vcnt;
    if (vs_fall)      vcnt_now = '0;
    else if (hs_fall) vcnt_now = vcnt + 10'd1;
  end

  assign hs_period_ok = (hcnt + 10'd1) == 10'(H_TOTAL);
  assign vs_len_ok    = (vcnt + 10'd1) == 10'(V_TOTAL);

  logic [9:0] ax, ay;
  logic       ax_ok, ay_ok, hit;
  logic [7:0] wdata_nxt;
  logic [8:0] waddr_nxt;

  assign ax        = hcnt_now - 10'(H_SYNC_TO_ACTIVE);
  assign ay        = vcnt_now - 10'(VS_TO_ACTIVE);
  assign ax_ok     = (hcnt_now >= 10'(H_SYNC_TO_ACTIVE)) && (ax < 10'(H_ACTIVE));
  assign ay_ok     = (vcnt_now >= 10'(VS_TO_ACTIVE)) && (ay < 10'(V_ACTIVE));
  assign hit       = (state == CAPTURE) && ax_ok && ay_ok && (ax[4:0] == 5'd16) && (ay[4:0] == 5'd16);
  assign wdata_nxt = {2'b00, r_q, g_q, b_q};
  assign waddr_nxt = 9'(BASE_ADDR) + 9'(ax[9:5]) + 9'(ay[8:5]) * 9'd20;

  logic good, good_nxt, seen_hs;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= SEARCH;
      good    <= 1'b0;
      seen_hs <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      state   <= state_nxt;
      good    <= good_nxt;
      seen_hs <= seen_hs | hs_fall;
      hcnt    <= hcnt_now;
      vcnt    <= vcnt_now;
    end
  end

  // The first HS fall after reset only starts a period; it cannot vouch for a line length.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      SEARCH: begin
        if (hs_fall) begin
          if (seen_hs && hs_period_ok) begin
            if (good) begin
              state_nxt = WAIT_VS;
              good_nxt  = 1'b0;
            end else begin
              good_nxt = 1'b1;
            end
          end else begin
            good_nxt = 1'b0;
          end
        end
      end
      WAIT_VS: begin
        if (vs_fall) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if ((hs_fall && !hs_period_ok) || (vs_fall && !vs_len_ok)) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  logic [8:0] cell_cnt;
  logic       done_evt;
  logic       wr_en_q;
  logic [8:0] wr_addr_q;
  logic [7:0] wr_data_q;

  assign done_evt = vs_fall && (state == CAPTURE) && (state_nxt == CAPTURE) && (cell_cnt == 9'(CELLS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      frame_done <= 1'b0;
      cell_cnt   <= '0;
    end else begin
      wr_en_q    <= hit;
      frame_done <= done_evt;
      if (hit) begin
        wr_addr_q <= waddr_nxt;
        wr_data_q <= wdata_nxt;
      end
      if (vs_fall)  cell_cnt <= '0;
      else if (hit) cell_cnt <= cell_cnt + 9'd1;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign locked      = (state == CAPTURE);

`ifdef VGA_CAP_SIG_EN
  logic [7:0] sig_acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sig_acc   <= '0;
      frame_sig <= '0;
    end else begin
      if (vs_fall)  sig_acc <= '0;
      else if (hit) sig_acc <= {sig_acc[6:0], sig_acc[7]} ^ wdata_nxt;
      if (done_evt) frame_sig <= sig_acc;
    end
  end
`else
  assign frame_sig = 8'h00;
`endif
endmodule
